// File: rtl/input_handler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_handler_pkg
//  Description : Shared definitions for the memory-game user-entry path.
//                Holds the default guess width and the collector state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_handler_pkg;

    // Default guess width, which is also the longest pattern a round can hold.
    localparam int c_DEFAULT_WIDTH = 16;

    // Collector states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage : input_handler_pkg
`default_nettype wire

// File: rtl/input_handler_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_handler_if
//  Description : User-entry bus between the game controller and the
//                serial-to-parallel collector.
//                  in             - serial user bit
//                  en             - collection enable
//                  count          - requested number of bits per round
//                  received_input - a complete guess is held
//                  user_guess     - collected bits, right-aligned, MSB first
//                master : drives in/en/count (controller / bench)
//                slave  : the collector
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_handler_if #(
    parameter int WIDTH = input_handler_pkg::c_DEFAULT_WIDTH
);
    logic             in;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             received_input;
    logic [WIDTH-1:0] user_guess;

    modport master (
        output in,
        output en,
        output count,
        input  received_input,
        input  user_guess
    );

    modport slave (
        input  in,
        input  en,
        input  count,
        output received_input,
        output user_guess
    );
endinterface : input_handler_if
`default_nettype wire

// File: rtl/input_handler.sv
`default_nettype none
// ============================================================================
//  Module      : input_handler
//  Description : Serial-to-parallel collector for the memory game. While
//                enabled it shifts one user bit per clock, MSB first, into a
//                WIDTH-bit guess register until the round length is reached,
//                then raises received_input and freezes user_guess until en
//                is dropped.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous reset, active HIGH (legacy name)
//                bus   - input_handler_if slave (in, en, count,
//                        received_input, user_guess)
//  Revision    : 1.0 - initial release
// ============================================================================
module input_handler
    import input_handler_pkg::*;
#(
    // Must be at least 2 (the shift path uses user_guess[WIDTH-2:0]).
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input_handler_if.slave bus
);

    // The counter must be able to hold the value WIDTH itself.
    localparam int                 c_CNT_W     = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   c_WIDTH_VAL = WIDTH'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_guess;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_len;
    logic               r_recv;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_guess_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_len_nxt;
    logic               w_recv_nxt;
    logic [c_CNT_W-1:0] w_req_len;
    logic [c_CNT_W-1:0] w_cnt_inc;

    // Requested length clamped to the register width. A request of 0 is
    // left as 0 here and handled by the "<= 1" test below, so it still
    // captures the one bit sampled on the starting edge.
    assign w_req_len = (bus.count > c_WIDTH_VAL) ? c_CNT_MAX
                                                 : c_CNT_W'(bus.count);
    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_guess_nxt = r_guess;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_recv_nxt  = r_recv;

        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    // The first bit is sampled on the same edge that starts
                    // the round, so the previous guess is replaced here.
                    w_len_nxt   = w_req_len;
                    w_guess_nxt = {{(WIDTH-1){1'b0}}, bus.in};
                    w_cnt_nxt   = c_CNT_ONE;
                    if (w_req_len <= c_CNT_ONE) begin
                        w_state_nxt = DONE;
                        w_recv_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = COLLECT;
                    end
                end
            end

            COLLECT: begin
                // en low pauses the round without losing progress.
                if (bus.en) begin
                    w_guess_nxt = {r_guess[WIDTH-2:0], bus.in};
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = DONE;
                        w_recv_nxt  = 1'b1;
                    end
                end
            end

            DONE: begin
                // Guess stays frozen; the controller releases it by
                // dropping en.
                if (!bus.en) begin
                    w_state_nxt = IDLE;
                    w_recv_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_recv_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_guess <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_recv  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_guess <= w_guess_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_recv  <= w_recv_nxt;
        end
    end

    assign bus.user_guess     = r_guess;
    assign bus.received_input = r_recv;

endmodule : input_handler
`default_nettype wire

// File: tb/tb_input_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_handler
//  Description : Self-checking bench for input_handler. Stimulus tasks drive
//                one edge at a time and push the expected post-edge outputs
//                from a round-level reference model into a queue; a monitor
//                pops and compares after every edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_handler;

    localparam int c_W = 16;

    typedef struct {
        logic            recv;
        logic [c_W-1:0]  guess;
    } exp_t;

    logic clk;
    logic rst_n;

    input_handler_if #(.WIDTH(c_W)) bus ();

    input_handler #(.WIDTH(c_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Round-level reference model: the bits accepted so far this round,
    // the round's target length, and whether the round is complete.
    bit             m_in_round;
    bit             m_full;
    int             m_target;
    bit             m_bits[$];
    logic [c_W-1:0] m_shown;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [c_W-1:0] bits_value();
        int v = 0;
        foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
        return c_W'(v);
    endfunction

    task automatic model_reset();
        m_in_round = 1'b0;
        m_full     = 1'b0;
        m_target   = 0;
        m_bits.delete();
        m_shown    = '0;
    endtask

    // Drive one edge's inputs, predict the outputs after that edge, then
    // advance to 2 time units past the edge.
    task automatic drive(input bit e, input bit b, input int cnt);
        exp_t x;
        bus.en    = e;
        bus.in    = b;
        bus.count = c_W'(cnt);
        if (m_full) begin
            if (!e) begin
                m_full     = 1'b0;
                m_in_round = 1'b0;
            end
        end else if (!m_in_round) begin
            if (e) begin
                m_target = (cnt < 1) ? 1 : ((cnt > c_W) ? c_W : cnt);
                m_bits.delete();
                m_bits.push_back(b);
                m_in_round = 1'b1;
            end
        end else if (e) begin
            m_bits.push_back(b);
        end
        if (m_in_round && !m_full && m_bits.size() >= m_target)
            m_full = 1'b1;
        if (m_in_round)
            m_shown = bits_value();
        x.recv  = m_full;
        x.guess = m_shown;
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic drive_word(input logic [c_W-1:0] w, input int nbits,
                              input int cnt);
        logic [c_W-1:0] t;
        t = w;
        for (int i = nbits - 1; i >= 0; i--) drive(1'b1, t[i], cnt);
    endtask

    task automatic end_round();
        drive(1'b0, 1'b0, 0);
    endtask

    // Monitor: one comparison pair per edge while expectations are queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_received_input", {31'b0, bus.received_input},
                      {31'b0, e.recv});
                check("sb_user_guess", {16'b0, bus.user_guess},
                      {16'b0, e.guess});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int cur_cnt;
        bit e, b;

        rst_n     = 1'b1;
        bus.en    = 1'b0;
        bus.in    = 1'b0;
        bus.count = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_guess", {16'b0, bus.user_guess}, 32'h0);
        check("reset_recv", {31'b0, bus.received_input}, 32'h0);
        rst_n = 1'b0;
        #1;

        // Basic 5-bit round, then an ignored extra bit.
        drive(1, 1, 5); drive(1, 0, 5); drive(1, 1, 5); drive(1, 1, 5);
        drive(1, 0, 5);
        check("tp1_guess", {16'b0, bus.user_guess}, 32'h0016);
        check("tp1_recv", {31'b0, bus.received_input}, 32'h1);
        drive(1, 1, 5);
        check("tp1_frozen", {16'b0, bus.user_guess}, 32'h0016);
        end_round();
        check("tp1_release", {31'b0, bus.received_input}, 32'h0);
        check("tp1_hold", {16'b0, bus.user_guess}, 32'h0016);

        // Same stream with a two-cycle pause after the second bit.
        drive(1, 1, 5); drive(1, 0, 5);
        drive(0, 1, 5); drive(0, 1, 5);
        drive(1, 1, 5); drive(1, 1, 5);
        check("tp2_not_yet", {31'b0, bus.received_input}, 32'h0);
        drive(1, 0, 5);
        check("tp2_guess", {16'b0, bus.user_guess}, 32'h0016);
        end_round();

        // Full width, then an over-length request clamped to full width.
        drive_word(16'hA5C3, 16, 16);
        check("tp3_guess16", {16'b0, bus.user_guess}, 32'hA5C3);
        check("tp3_recv16", {31'b0, bus.received_input}, 32'h1);
        end_round();
        drive_word(16'hA5C3, 16, 20);
        check("tp3_guess20", {16'b0, bus.user_guess}, 32'hA5C3);
        end_round();

        // Short round after a completed one.
        drive(1, 1, 3);
        check("tp4_first", {16'b0, bus.user_guess}, 32'h0001);
        drive(1, 1, 3); drive(1, 1, 3);
        check("tp4_final", {16'b0, bus.user_guess}, 32'h0007);
        end_round();

        // Asynchronous reset mid-round.
        drive(1, 1, 5); drive(1, 0, 5); drive(1, 1, 5);
        bus.en = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check("tp5_async_guess", {16'b0, bus.user_guess}, 32'h0);
        check("tp5_async_recv", {31'b0, bus.received_input}, 32'h0);
        model_reset();
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        drive(1, 1, 2); drive(1, 0, 2);
        check("tp5_after", {16'b0, bus.user_guess}, 32'h0002);
        end_round();

        // Zero length behaves as length one.
        drive(1, 1, 0);
        check("tp6_guess", {16'b0, bus.user_guess}, 32'h0001);
        check("tp6_recv", {31'b0, bus.received_input}, 32'h1);
        end_round();

        // Randomized traffic, with count changing at random (including
        // mid-round, where it must be ignored).
        cur_cnt = 5;
        for (int i = 0; i < 500; i++) begin
            e = ($urandom_range(0, 9) < 8);
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) cur_cnt = int'($urandom_range(0, 20));
            drive(e, b, cur_cnt);
        end

        check("drain", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_input_handler
`default_nettype wire
